// File: rtl/pdm_rx.sv
// pdm_rx: Wishbone PDM microphone receiver; stereo capture on both pdm_clk edges,
// ones-count decimation over a 2^pBits window, samples and status readable over the bus.
module pdm_rx #(
   parameter int pBits     = 8,
   parameter int pChannels = 2,
   parameter int pClkDiv   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_adr,
   input  logic [31:0] wb_dat_c,
   output logic [31:0] wb_dat_p,
   output logic        wb_ack,
   output logic        pdm_clk,
   input  logic        pdm_dat
);
   localparam int DW = $clog2(pClkDiv);

   logic [DW-1:0]        r_div;
   logic                 r_pdm_clk;
   logic [1:0]           r_sync;
   logic [pBits-1:0]     r_win;
   logic [pBits:0]       r_acc  [pChannels];
   logic [pBits-1:0]     r_samp [pChannels];
   logic [pChannels-1:0] r_valid, r_ovr;
   logic                 r_ack;
   logic [31:0]          r_dat;

   logic                 w_tick, w_rise, w_fall, w_wend, w_acc, w_unused;
   logic [pChannels-1:0] w_cap, w_rd_clr, w_ovr_clr;
   logic [pBits:0]       w_next [pChannels];
   logic [31:0]          w_rdata;

   assign w_tick   = r_div == DW'(pClkDiv - 1);
   assign w_rise   = w_tick & ~r_pdm_clk;
   assign w_fall   = w_tick & r_pdm_clk;
   assign w_wend   = w_rise & (&r_win);
   assign w_acc    = wb_stb & ~r_ack;
   assign w_unused = ^wb_dat_c;
   assign pdm_clk  = r_pdm_clk;
   assign wb_ack   = r_ack;
   assign wb_dat_p = r_dat;

   // Channel 0 captures on the falling toggle, channel 1 on the rising toggle.
   always_comb begin
      w_rdata   = '0;
      w_cap     = '0;
      w_rd_clr  = '0;
      w_ovr_clr = '0;
      for (int c = 0; c < pChannels; c++) begin
         w_cap[c]     = (c == 0) ? w_fall : w_rise;
         w_next[c]    = r_acc[c] + (pBits+1)'(w_cap[c] & r_sync[1]);
         w_rd_clr[c]  = w_acc & ~wb_we & (wb_adr == 4'(c));
         w_ovr_clr[c] = w_acc & wb_we & (wb_adr == 4'd8) & wb_dat_c[8+c];
         if (wb_adr == 4'(c)) w_rdata[pBits-1:0] = r_samp[c];
      end
      if (wb_adr == 4'd8) begin
         w_rdata[pChannels-1:0] = r_valid;
         w_rdata[8 +: pChannels] = r_ovr;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_div     <= '0;
         r_pdm_clk <= 1'b0;
         r_sync    <= '0;
         r_win     <= '0;
         r_valid   <= '0;
         r_ovr     <= '0;
         r_ack     <= 1'b0;
         r_dat     <= '0;
         for (int c = 0; c < pChannels; c++) begin
            r_acc[c]  <= '0;
            r_samp[c] <= '0;
         end
      end else begin
         r_div     <= w_tick ? '0 : r_div + 1'b1;
         r_pdm_clk <= r_pdm_clk ^ w_tick;
         r_sync    <= {r_sync[0], pdm_dat};
         r_win     <= r_win + pBits'(w_rise);
         r_valid   <= (r_valid & ~w_rd_clr) | {pChannels{w_wend}};
         r_ovr     <= (r_ovr & ~w_ovr_clr) | ({pChannels{w_wend}} & r_valid);
         r_ack     <= w_acc;
         if (w_acc) r_dat <= w_rdata;
         for (int c = 0; c < pChannels; c++) begin
            if (w_wend) begin
               r_samp[c] <= w_next[c][pBits] ? '1 : w_next[c][pBits-1:0];
               r_acc[c]  <= '0;
            end else begin
               r_acc[c]  <= w_next[c];
            end
         end
      end
   end
endmodule

// File: tb/tb_pdm_rx.sv
// tb_pdm_rx: directed bench for pdm_rx (pBits=8, pChannels=2, pClkDiv=4); window ends
// on edge 2044 + 2048*n after reset release.
module tb_pdm_rx;
   logic        clk = 1'b0, rst = 1'b1, wb_stb = 1'b0, wb_we = 1'b0, pdm_dat = 1'b0;
   logic [3:0]  wb_adr = '0;
   logic [31:0] wb_dat_c = '0, wb_dat_p;
   logic        wb_ack, pdm_clk;
   logic        alt = 1'b1;
   int          mode = 0, cyc = 0, pass_cnt = 0, total = 0;

   always #5 clk = ~clk;

   pdm_rx #(.pBits(8), .pChannels(2), .pClkDiv(4)) dut (
      .clk(clk), .rst(rst), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
      .wb_dat_c(wb_dat_c), .wb_dat_p(wb_dat_p), .wb_ack(wb_ack),
      .pdm_clk(pdm_clk), .pdm_dat(pdm_dat)
   );

   always @(posedge clk or negedge rst)
      if (!rst) cyc <= 0;
      else cyc <= cyc + 1;

   // mode 0: zeros, 1: ones, 2: one only while pdm_clk high, 3: ch0 alternates, ch1 ones
   always @(negedge pdm_clk) alt = ~alt;
   always @(negedge clk)
      pdm_dat = (mode == 1) ? 1'b1 : (mode == 2) ? pdm_clk : (mode == 3) ? (pdm_clk ? alt : 1'b1) : 1'b0;

   task automatic do_reset(input int m);
      rst = 1'b0;
      mode = m;
      repeat (3) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] d, output logic [31:0] q);
      wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_c = d;
      @(negedge clk);
      q = wb_ack ? wb_dat_p : 32'hDEAD_BEEF;
      wb_stb = 1'b0; wb_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [31:0] q;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (pdm_clk !== 1'b0) $display("FAIL reset_pdm_clk got %b exp 0", pdm_clk); else pass_cnt++;
      total++; if (wb_ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", wb_ack); else pass_cnt++;
      total++; if (wb_dat_p !== 32'h0) $display("FAIL reset_dat got %h exp 0", wb_dat_p); else pass_cnt++;
      rst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         total++;
         if (pdm_clk !== (k == 4)) $display("FAIL first_rise clk%0d got %b exp %b", k, pdm_clk, k == 4);
         else pass_cnt++;
      end
      wb(1'b0, 4'd8, 32'h0, q);
      total++; if (q !== 32'h0) $display("FAIL reset_status got %h exp 0", q); else pass_cnt++;
   endtask

   task automatic test_ones();
      logic [31:0] q;
      logic [3:0]  adr [4] = '{4'd8, 4'd0, 4'd1, 4'd8};
      logic [31:0] exp [4] = '{32'h3, 32'hFF, 32'hFF, 32'h0};
      do_reset(1);
      wait_cyc(2044);
      for (int i = 0; i < 4; i++) begin
         wb(1'b0, adr[i], 32'h0, q);
         total++;
         if (q !== exp[i]) $display("FAIL ones_rd%0d adr %0d got %h exp %h", i, adr[i], q, exp[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_zeros();
      logic [31:0] q;
      logic [3:0]  adr [3] = '{4'd8, 4'd0, 4'd1};
      logic [31:0] exp [3] = '{32'h3, 32'h0, 32'h0};
      do_reset(1);
      wait_cyc(1000);
      do_reset(0);
      wait_cyc(2044);
      for (int i = 0; i < 3; i++) begin
         wb(1'b0, adr[i], 32'h0, q);
         total++;
         if (q !== exp[i]) $display("FAIL zeros_rd%0d adr %0d got %h exp %h", i, adr[i], q, exp[i]);
         else pass_cnt++;
      end
      do_reset(2);
      wait_cyc(2044);
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'hFF) $display("FAIL high_only_ch0 got %h exp ff", q); else pass_cnt++;
      wb(1'b0, 4'd1, 32'h0, q);
      total++; if (q !== 32'h0) $display("FAIL high_only_ch1 got %h exp 0", q); else pass_cnt++;
   endtask

   task automatic test_alt();
      logic [31:0] q;
      do_reset(3);
      wait_cyc(4092);
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'h80) $display("FAIL alt_ch0 got %h exp 80", q); else pass_cnt++;
      wb(1'b0, 4'd1, 32'h0, q);
      total++; if (q !== 32'hFF) $display("FAIL alt_ch1 got %h exp ff", q); else pass_cnt++;
   endtask

   task automatic test_overrun();
      logic [31:0] q;
      do_reset(1);
      wait_cyc(4092);
      wb(1'b0, 4'd8, 32'h0, q);
      total++; if (q !== 32'h303) $display("FAIL ovr_status got %h exp 303", q); else pass_cnt++;
      wb(1'b1, 4'd8, 32'h100, q);
      wb(1'b0, 4'd8, 32'h0, q);
      total++; if (q !== 32'h203) $display("FAIL ovr_clear got %h exp 203", q); else pass_cnt++;
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'hFF) $display("FAIL ovr_ch0 got %h exp ff", q); else pass_cnt++;
      wb(1'b0, 4'd8, 32'h0, q);
      total++; if (q !== 32'h202) $display("FAIL ovr_after_rd got %h exp 202", q); else pass_cnt++;
   endtask

   task automatic test_window_edge();
      logic [31:0] q;
      do_reset(0);
      wait_cyc(2044);
      mode = 1;
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'h0) $display("FAIL edge_pre_ch0 got %h exp 0", q); else pass_cnt++;
      wb(1'b0, 4'd1, 32'h0, q);
      total++; if (q !== 32'h0) $display("FAIL edge_pre_ch1 got %h exp 0", q); else pass_cnt++;
      wait_cyc(4091);
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'h0) $display("FAIL edge_rd_old got %h exp 0", q); else pass_cnt++;
      wb(1'b0, 4'd8, 32'h0, q);
      total++; if (q !== 32'h3) $display("FAIL edge_valid got %h exp 3", q); else pass_cnt++;
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'hFF) $display("FAIL edge_rd_new got %h exp ff", q); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] q;
      wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'd5;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (wb_ack !== (k % 2 == 0)) $display("FAIL b2b_ack cyc%0d got %b exp %b", k, wb_ack, k % 2 == 0);
         else pass_cnt++;
         if (k % 2 == 0) begin
            total++;
            if (wb_dat_p !== 32'h0) $display("FAIL b2b_adr5 cyc%0d got %h exp 0", k, wb_dat_p);
            else pass_cnt++;
         end
      end
      wb_stb = 1'b0;
      @(negedge clk);
      wb(1'b1, 4'd0, 32'h55, q);
      wb(1'b0, 4'd0, 32'h0, q);
      total++; if (q !== 32'hFF) $display("FAIL write_ignored got %h exp ff", q); else pass_cnt++;
   endtask

   initial begin
      #1000000;
      $display("FAIL timeout cyc %0d", cyc);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_ones();
      test_zeros();
      test_alt();
      test_overrun();
      test_window_edge();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
